// File: rtl/mem_access_stage_if.sv
// Execute-to-memory, memory-to-writeback and data-SRAM response signals of the memory stage.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface mem_access_stage_if #(
  parameter int EXC_WD = 64
);
  logic                ws_allowin;
  logic                ms_allowin;
  logic                es_to_ms_valid;
  logic [EXC_WD+78:0]  es_to_ms_bus;
  logic                ms_to_ws_valid;
  logic [EXC_WD+70:0]  ms_to_ws_bus;
  logic [38:0]         ms_fwd_bus;
  logic                ms_ex;
  logic                data_sram_data_ok;
  logic [31:0]         data_sram_rdata;
  logic                ms_flush_pipe;

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata, ms_flush_pipe,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, aligns/extends load data,
// forwards to writeback, and silently drops the response of a load killed by a flush.
module mem_access_stage #(
  parameter int EXC_WD = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.slave  ms
);

  // state | meaning
  // EMPTY | no instruction held
  // RUN   | instruction needs no memory data, ready to leave
  // WAIT  | load/store issued, response not yet seen
  // HAVE  | response captured in rdata_buf, waiting for writeback
  typedef enum logic [1:0] {EMPTY, RUN, WAIT, HAVE} state_t;

  state_t              state_q, state_d;
  logic                drop_pending_q, drop_pending_d;
  logic [31:0]         rdata_buf_q, rdata_buf_d;
  logic [EXC_WD-1:0]   exc_q;
  logic                ex_q;
  logic [4:0]          load_op_q;
  logic                res_from_mem_q;
  logic                gr_we_q;
  logic [4:0]          dest_q;
  logic [31:0]         result_q;
  logic [31:0]         pc_q;

  logic                in_ex, in_mem_req, in_need_data;
  logic                ms_valid, ms_ready_go, data_ok_own, capture;
  logic [31:0]         raw, half_sel, final_result;
  logic [7:0]          byte_sel;

  assign in_ex        = ms.es_to_ms_bus[77];
  assign in_mem_req   = ms.es_to_ms_bus[76];
  assign in_need_data = in_mem_req && !in_ex;

  assign ms_valid    = (state_q != EMPTY);
  // A response arriving while drop_pending is set belongs to a flushed load.
  assign data_ok_own = ms.data_sram_data_ok && !drop_pending_q;
  assign ms_ready_go = (state_q == RUN) || (state_q == HAVE) ||
                       ((state_q == WAIT) && data_ok_own);
  assign ms.ms_allowin = !ms_valid || (ms_ready_go && ms.ws_allowin);
  assign capture       = ms.es_to_ms_valid && ms.ms_allowin && !ms.ms_flush_pipe;

  assign raw = ((state_q == WAIT) && data_ok_own) ? ms.data_sram_rdata : rdata_buf_q;

  always_comb begin
    byte_sel = raw[7:0];
    case (result_q[1:0])
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = {16'h0, result_q[1] ? raw[31:16] : raw[15:0]};
  end

  always_comb begin
    final_result = result_q;
    if (res_from_mem_q && !ex_q) begin
      if (load_op_q[0])      final_result = {{24{byte_sel[7]}}, byte_sel};
      else if (load_op_q[1]) final_result = {{16{half_sel[15]}}, half_sel[15:0]};
      else if (load_op_q[3]) final_result = {24'h0, byte_sel};
      else if (load_op_q[4]) final_result = half_sel;
      else                   final_result = raw;
    end
  end

  assign ms.ms_to_ws_valid = ms_valid && ms_ready_go && !ms.ms_flush_pipe;
  assign ms.ms_to_ws_bus   = {exc_q, ex_q, gr_we_q, dest_q, final_result, pc_q};
  assign ms.ms_fwd_bus     = {ms_valid && gr_we_q,
                              ms_valid && res_from_mem_q && !ms_ready_go,
                              dest_q, final_result};
  assign ms.ms_ex          = ms_valid && ex_q;

  always_comb begin
    state_d        = state_q;
    drop_pending_d = drop_pending_q;
    rdata_buf_d    = rdata_buf_q;
    if (drop_pending_q && ms.data_sram_data_ok)
      drop_pending_d = 1'b0;
    if (ms.ms_flush_pipe) begin
      state_d = EMPTY;
      // An unanswered request of the killed load must be swallowed later.
      if ((state_q == WAIT) && !data_ok_own)
        drop_pending_d = 1'b1;
    end else if (ms.ms_allowin) begin
      if (ms.es_to_ms_valid) state_d = in_need_data ? WAIT : RUN;
      else                   state_d = EMPTY;
    end else if ((state_q == WAIT) && data_ok_own) begin
      state_d     = HAVE;
      rdata_buf_d = ms.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= EMPTY;
      drop_pending_q <= 1'b0;
      rdata_buf_q    <= 32'h0;
      exc_q          <= '0;
      ex_q           <= 1'b0;
      load_op_q      <= 5'h0;
      res_from_mem_q <= 1'b0;
      gr_we_q        <= 1'b0;
      dest_q         <= 5'h0;
      result_q       <= 32'h0;
      pc_q           <= 32'h0;
    end else begin
      state_q        <= state_d;
      drop_pending_q <= drop_pending_d;
      rdata_buf_q    <= rdata_buf_d;
      if (capture) begin
        exc_q          <= ms.es_to_ms_bus[EXC_WD+77:78];
        ex_q           <= in_ex;
        load_op_q      <= ms.es_to_ms_bus[75:71];
        res_from_mem_q <= ms.es_to_ms_bus[70];
        gr_we_q        <= ms.es_to_ms_bus[69];
        dest_q         <= ms.es_to_ms_bus[68:64];
        result_q       <= ms.es_to_ms_bus[63:32];
        pc_q           <= ms.es_to_ms_bus[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: load alignment, stall in HAVE, ALU forwarding,
// flush with stale-response drop, exception pass-through and reset during WAIT.
module tb_mem_access_stage;
  localparam int EXC_WD = 64;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.EXC_WD(EXC_WD)) bus_if ();

  mem_access_stage #(.EXC_WD(EXC_WD)) dut (
    .clk   (clk),
    .reset (reset),
    .ms    (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXC_WD+78:0] mk(input logic [EXC_WD-1:0] exc, input logic ex,
      input logic mem_req, input logic [4:0] load_op, input logic res_from_mem,
      input logic gr_we, input logic [4:0] dest, input logic [31:0] result,
      input logic [31:0] pc);
    return {1'b0, exc, ex, mem_req, load_op, res_from_mem, gr_we, dest, result, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Offer one instruction, capture it on the next edge, then stop offering.
  task automatic issue(input logic [EXC_WD+78:0] b);
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = b;
    tick();
    bus_if.es_to_ms_valid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [4:0] op, input logic [31:0] addr,
      input logic [31:0] rdata, input logic [31:0] exp);
    issue(mk('0, 1'b0, 1'b1, op, 1'b1, 1'b1, 5'd7, addr, 32'h100));
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = rdata;
    settle();
    chk({tag, "_valid"}, 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk({tag, "_res"},   64'(bus_if.ms_to_ws_bus[63:32]), 64'(exp));
    tick();
    bus_if.data_sram_data_ok = 1'b0;
  endtask

  initial begin
    reset                    = 1'b1;
    bus_if.ws_allowin        = 1'b1;
    bus_if.es_to_ms_valid    = 1'b0;
    bus_if.es_to_ms_bus      = '0;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = 32'h0;
    bus_if.ms_flush_pipe     = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_allowin", 64'(bus_if.ms_allowin), 64'd1);
    chk("rst_valid",   64'(bus_if.ms_to_ws_valid), 64'd0);
    chk("rst_ex",      64'(bus_if.ms_ex), 64'd0);
    chk("rst_fwdblk",  64'(bus_if.ms_fwd_bus[38:37]), 64'd0);
    tick();

    // ld.w, response on the third cycle after capture
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd3, 32'h1000, 32'h200));
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("ldw_blk",     64'(bus_if.ms_fwd_bus[37]), 64'd1);
      chk("ldw_novalid", 64'(bus_if.ms_to_ws_valid), 64'd0);
      chk("ldw_allowin", 64'(bus_if.ms_allowin), 64'd0);
      tick();
    end
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'hDEADBEEF;
    settle();
    chk("ldw_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("ldw_res",   64'(bus_if.ms_to_ws_bus[63:32]), 64'hDEADBEEF);
    chk("ldw_blk0",  64'(bus_if.ms_fwd_bus[37]), 64'd0);
    chk("ldw_dest",  64'(bus_if.ms_to_ws_bus[68:64]), 64'd3);
    chk("ldw_pc",    64'(bus_if.ms_to_ws_bus[31:0]), 64'h200);
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    settle();
    chk("ldw_gone", 64'(bus_if.ms_to_ws_valid), 64'd0);

    load_case("ldb",  5'b00001, 32'h1003, 32'h80FF0011, 32'hFFFFFF80);
    load_case("ldbu", 5'b01000, 32'h1003, 32'h80FF0011, 32'h00000080);
    load_case("ldh",  5'b00010, 32'h1002, 32'h80FF0011, 32'hFFFF80FF);
    load_case("ldhu", 5'b10000, 32'h1002, 32'h80FF0011, 32'h000080FF);
    load_case("ldb1", 5'b00001, 32'h1001, 32'h80FF0011, 32'h00000000);

    // writeback stalls, response held in HAVE
    bus_if.ws_allowin = 1'b0;
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd4, 32'h1010, 32'h300));
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h13572468;
    settle();
    chk("have_allowin0", 64'(bus_if.ms_allowin), 64'd0);
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata   = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("have_allowin", 64'(bus_if.ms_allowin), 64'd0);
      chk("have_res",     64'(bus_if.ms_to_ws_bus[63:32]), 64'h13572468);
      tick();
    end
    bus_if.ws_allowin = 1'b1;
    settle();
    chk("have_release", 64'(bus_if.ms_allowin), 64'd1);
    chk("have_valid",   64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("have_final",   64'(bus_if.ms_to_ws_bus[63:32]), 64'h13572468);
    tick();

    // ALU op forwarding
    issue(mk('0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 5'd5, 32'h12, 32'h400));
    settle();
    chk("alu_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("alu_fwd",   64'(bus_if.ms_fwd_bus), 64'({1'b1, 1'b0, 5'd5, 32'h12}));
    tick();

    // flush during WAIT, stale response must be dropped
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd6, 32'h2000, 32'h500));
    bus_if.ms_flush_pipe = 1'b1;
    settle();
    chk("fl_mask", 64'(bus_if.ms_to_ws_valid), 64'd0);
    tick();
    bus_if.ms_flush_pipe = 1'b0;
    settle();
    chk("fl_empty", 64'(bus_if.ms_allowin), 64'd1);
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd8, 32'h3000, 32'h600));
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0000AAAA;
    settle();
    chk("fl_stale",    64'(bus_if.ms_to_ws_valid), 64'd0);
    chk("fl_stale_bk", 64'(bus_if.ms_fwd_bus[37]), 64'd1);
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    settle();
    chk("fl_wait", 64'(bus_if.ms_to_ws_valid), 64'd0);
    tick();
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h00005555;
    settle();
    chk("fl_own_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("fl_own_res",   64'(bus_if.ms_to_ws_bus[63:32]), 64'h5555);
    tick();
    bus_if.data_sram_data_ok = 1'b0;

    // exception carried through without waiting for memory
    issue(mk(64'hCAFE_0000_1234_5678, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h4000, 32'h700));
    settle();
    chk("ex_flag",  64'(bus_if.ms_ex), 64'd1);
    chk("ex_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("ex_bit",   64'(bus_if.ms_to_ws_bus[70]), 64'd1);
    chk("ex_exc",   bus_if.ms_to_ws_bus[EXC_WD+70:71], 64'hCAFE_0000_1234_5678);
    chk("ex_res",   64'(bus_if.ms_to_ws_bus[63:32]), 64'h4000);
    tick();
    settle();
    chk("ex_clear", 64'(bus_if.ms_ex), 64'd0);

    // flush with simultaneous response: nothing left to drop
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd10, 32'h5000, 32'h800));
    bus_if.ms_flush_pipe     = 1'b1;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0000BBBB;
    tick();
    bus_if.ms_flush_pipe     = 1'b0;
    bus_if.data_sram_data_ok = 1'b0;
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd11, 32'h6000, 32'h900));
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h00007777;
    settle();
    chk("fldo_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("fldo_res",   64'(bus_if.ms_to_ws_bus[63:32]), 64'h7777);
    tick();
    bus_if.data_sram_data_ok = 1'b0;

    // reset during WAIT, late response ignored
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd12, 32'h7000, 32'hA00));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0000CCCC;
    settle();
    chk("rw_valid",   64'(bus_if.ms_to_ws_valid), 64'd0);
    chk("rw_allowin", 64'(bus_if.ms_allowin), 64'd1);
    tick();
    bus_if.data_sram_data_ok = 1'b0;
    issue(mk('0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 5'd13, 32'h8000, 32'hB00));
    bus_if.data_sram_data_ok = 1'b1;
    bus_if.data_sram_rdata   = 32'h0000DDDD;
    settle();
    chk("rw_next_valid", 64'(bus_if.ms_to_ws_valid), 64'd1);
    chk("rw_next_res",   64'(bus_if.ms_to_ws_bus[63:32]), 64'hDDDD);
    tick();
    bus_if.data_sram_data_ok = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
